// File: rtl/ltpi_pkg.sv
// Shared LTPI capability types and limits used by the parameterization block.
package ltpi_pkg;

   typedef struct packed {
      logic [15:0] speed;
      logic [9:0]  nl_gpio;
      logic [5:0]  i2c;
      logic [3:0]  uart;
      logic        data_ch;
   } ltpi_cap_t;

   localparam int LTPI_MAX_NL_GPIO = 1023;
   localparam int LTPI_MAX_I2C     = 6;
   localparam int LTPI_MAX_UART    = 4;

   function automatic logic [9:0] ltpi_min10(input logic [9:0] a, input logic [9:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/ltpi_speed_select.sv
// 16-bit highest-set-bit priority encoder for link speed selection.
module ltpi_speed_select (
   input  logic [15:0] req,
   output logic [3:0]  idx,
   output logic        none
);
   always_comb begin
      idx  = '0;
      none = (req == '0);
      for (int i = 0; i < 16; i++) begin
         if (req[i]) idx = 4'(i);
      end
   end
endmodule

// File: rtl/ltpi_parameterize.sv
// LTPI capability advertise/negotiation: local caps from parameters, registered operational config.
// Optional data channel support is enabled by defining LTPI_DATA_CHANNEL_EN.
module ltpi_parameterize
   import ltpi_pkg::*;
#(
   parameter bit          ROLE_CONTROLLER = 1'b1,
   parameter logic [15:0] SPEED_CAP       = 16'h0001,
   parameter int          NUM_NL_GPIO     = 64,
   parameter int          NUM_I2C         = 6,
   parameter int          NUM_UART        = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        remote_valid,
   input  logic [15:0] remote_speed_cap,
   input  logic [9:0]  remote_nl_gpio,
   input  logic [5:0]  remote_i2c_en,
   input  logic [3:0]  remote_uart_en,
   input  logic        remote_data_ch,
   output logic [15:0] local_speed_cap,
   output logic [9:0]  local_nl_gpio,
   output logic [5:0]  local_i2c_en,
   output logic [3:0]  local_uart_en,
   output logic        local_data_ch,
   output logic [3:0]  oper_speed_idx,
   output logic [9:0]  oper_nl_gpio,
   output logic [5:0]  oper_i2c_en,
   output logic [3:0]  oper_uart_en,
   output logic        oper_data_ch,
   output logic        cfg_done,
   output logic        cfg_error
);

   if (SPEED_CAP[0] == 1'b0 || NUM_NL_GPIO < 0 || NUM_NL_GPIO > LTPI_MAX_NL_GPIO ||
       NUM_I2C < 0 || NUM_I2C > LTPI_MAX_I2C || NUM_UART < 0 || NUM_UART > LTPI_MAX_UART) begin : g_bad_param
      $fatal(1, "ltpi_parameterize: invalid capability parameters");
   end

`ifdef LTPI_DATA_CHANNEL_EN
   localparam logic LOC_DATA_CH = 1'b1;
`else
   localparam logic LOC_DATA_CH = 1'b0;
`endif

   localparam ltpi_cap_t LOC_CAP = '{
      speed:   SPEED_CAP,
      nl_gpio: 10'(NUM_NL_GPIO),
      i2c:     6'((1 << NUM_I2C) - 1),
      uart:    4'((1 << NUM_UART) - 1),
      data_ch: LOC_DATA_CH
   };

   ltpi_cap_t rem_cap;
   logic [3:0] sel_idx;
   logic       sel_none;
   logic       tgt_accept;

   logic [3:0] spd_idx_q, spd_idx_d;
   logic [9:0] nl_gpio_q, nl_gpio_d;
   logic [5:0] i2c_q, i2c_d;
   logic [3:0] uart_q, uart_d;
   logic       data_ch_q, data_ch_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   // Masking with the local capability makes remote_data_ch a don't-care when the feature is off.
   assign rem_cap = '{
      speed:   remote_speed_cap,
      nl_gpio: remote_nl_gpio,
      i2c:     remote_i2c_en,
      uart:    remote_uart_en,
      data_ch: remote_data_ch & LOC_DATA_CH
   };

   ltpi_speed_select u_speed_select (
      .req  (LOC_CAP.speed & rem_cap.speed),
      .idx  (sel_idx),
      .none (sel_none)
   );

   // Target accepts only a single selected speed that we support and subsets of our caps.
   assign tgt_accept = (rem_cap.speed != '0) &&
                       ((rem_cap.speed & (rem_cap.speed - 16'd1)) == '0) &&
                       !sel_none &&
                       (rem_cap.nl_gpio <= LOC_CAP.nl_gpio) &&
                       ((rem_cap.i2c & ~LOC_CAP.i2c) == '0) &&
                       ((rem_cap.uart & ~LOC_CAP.uart) == '0) &&
                       ((rem_cap.data_ch & ~LOC_CAP.data_ch) == 1'b0);

   always_comb begin
      spd_idx_d = spd_idx_q;
      nl_gpio_d = nl_gpio_q;
      i2c_d     = i2c_q;
      uart_d    = uart_q;
      data_ch_d = data_ch_q;
      done_d    = done_q;
      err_d     = err_q;
      if (clear) begin
         spd_idx_d = '0;
         nl_gpio_d = '0;
         i2c_d     = '0;
         uart_d    = '0;
         data_ch_d = 1'b0;
         done_d    = 1'b0;
         err_d     = 1'b0;
      end else if (remote_valid) begin
         if (ROLE_CONTROLLER ? sel_none : !tgt_accept) begin
            done_d = 1'b0;
            err_d  = 1'b1;
         end else begin
            spd_idx_d = sel_idx;
            nl_gpio_d = ROLE_CONTROLLER ? ltpi_min10(LOC_CAP.nl_gpio, rem_cap.nl_gpio) : rem_cap.nl_gpio;
            i2c_d     = ROLE_CONTROLLER ? (LOC_CAP.i2c & rem_cap.i2c) : rem_cap.i2c;
            uart_d    = ROLE_CONTROLLER ? (LOC_CAP.uart & rem_cap.uart) : rem_cap.uart;
            data_ch_d = LOC_CAP.data_ch & rem_cap.data_ch;
            done_d    = 1'b1;
            err_d     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spd_idx_q <= '0;
         nl_gpio_q <= '0;
         i2c_q     <= '0;
         uart_q    <= '0;
         data_ch_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         spd_idx_q <= spd_idx_d;
         nl_gpio_q <= nl_gpio_d;
         i2c_q     <= i2c_d;
         uart_q    <= uart_d;
         data_ch_q <= data_ch_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign local_speed_cap = LOC_CAP.speed;
   assign local_nl_gpio   = LOC_CAP.nl_gpio;
   assign local_i2c_en    = LOC_CAP.i2c;
   assign local_uart_en   = LOC_CAP.uart;
   assign local_data_ch   = LOC_CAP.data_ch;

   assign oper_speed_idx  = spd_idx_q;
   assign oper_nl_gpio    = nl_gpio_q;
   assign oper_i2c_en     = i2c_q;
   assign oper_uart_en    = uart_q;
   assign oper_data_ch    = data_ch_q;
   assign cfg_done        = done_q;
   assign cfg_error       = err_q;

endmodule

// File: tb/tb_ltpi_parameterize.sv
// Directed bench: two controllers (SPEED_CAP F and 1) and one target (SPEED_CAP 7) on shared stimulus.
module tb_ltpi_parameterize;

`ifdef LTPI_DATA_CHANNEL_EN
   localparam logic DCH = 1'b1;
`else
   localparam logic DCH = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        clear = 1'b0;
   logic        remote_valid = 1'b0;
   logic [15:0] r_spd = '0;
   logic [9:0]  r_gpio = '0;
   logic [5:0]  r_i2c = '0;
   logic [3:0]  r_uart = '0;
   logic        r_dch = 1'b0;

   logic [15:0] l_spd [3];
   logic [9:0]  l_gpio [3];
   logic [5:0]  l_i2c [3];
   logic [3:0]  l_uart [3];
   logic        l_dch [3];
   logic [3:0]  o_spd [3];
   logic [9:0]  o_gpio [3];
   logic [5:0]  o_i2c [3];
   logic [3:0]  o_uart [3];
   logic        o_dch [3];
   logic        o_done [3];
   logic        o_err [3];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ltpi_parameterize #(.ROLE_CONTROLLER(1'b1), .SPEED_CAP(16'h000F), .NUM_NL_GPIO(64),
                       .NUM_I2C(6), .NUM_UART(2)) u_c0 (
      .clk(clk), .reset_n(reset_n), .clear(clear), .remote_valid(remote_valid),
      .remote_speed_cap(r_spd), .remote_nl_gpio(r_gpio), .remote_i2c_en(r_i2c),
      .remote_uart_en(r_uart), .remote_data_ch(r_dch),
      .local_speed_cap(l_spd[0]), .local_nl_gpio(l_gpio[0]), .local_i2c_en(l_i2c[0]),
      .local_uart_en(l_uart[0]), .local_data_ch(l_dch[0]),
      .oper_speed_idx(o_spd[0]), .oper_nl_gpio(o_gpio[0]), .oper_i2c_en(o_i2c[0]),
      .oper_uart_en(o_uart[0]), .oper_data_ch(o_dch[0]), .cfg_done(o_done[0]), .cfg_error(o_err[0]));

   ltpi_parameterize #(.ROLE_CONTROLLER(1'b1), .SPEED_CAP(16'h0001), .NUM_NL_GPIO(64),
                       .NUM_I2C(6), .NUM_UART(2)) u_c1 (
      .clk(clk), .reset_n(reset_n), .clear(clear), .remote_valid(remote_valid),
      .remote_speed_cap(r_spd), .remote_nl_gpio(r_gpio), .remote_i2c_en(r_i2c),
      .remote_uart_en(r_uart), .remote_data_ch(r_dch),
      .local_speed_cap(l_spd[1]), .local_nl_gpio(l_gpio[1]), .local_i2c_en(l_i2c[1]),
      .local_uart_en(l_uart[1]), .local_data_ch(l_dch[1]),
      .oper_speed_idx(o_spd[1]), .oper_nl_gpio(o_gpio[1]), .oper_i2c_en(o_i2c[1]),
      .oper_uart_en(o_uart[1]), .oper_data_ch(o_dch[1]), .cfg_done(o_done[1]), .cfg_error(o_err[1]));

   ltpi_parameterize #(.ROLE_CONTROLLER(1'b0), .SPEED_CAP(16'h0007), .NUM_NL_GPIO(64),
                       .NUM_I2C(2), .NUM_UART(2)) u_t (
      .clk(clk), .reset_n(reset_n), .clear(clear), .remote_valid(remote_valid),
      .remote_speed_cap(r_spd), .remote_nl_gpio(r_gpio), .remote_i2c_en(r_i2c),
      .remote_uart_en(r_uart), .remote_data_ch(r_dch),
      .local_speed_cap(l_spd[2]), .local_nl_gpio(l_gpio[2]), .local_i2c_en(l_i2c[2]),
      .local_uart_en(l_uart[2]), .local_data_ch(l_dch[2]),
      .oper_speed_idx(o_spd[2]), .oper_nl_gpio(o_gpio[2]), .oper_i2c_en(o_i2c[2]),
      .oper_uart_en(o_uart[2]), .oper_data_ch(o_dch[2]), .cfg_done(o_done[2]), .cfg_error(o_err[2]));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic chk_oper(input int k, input string tag, input logic [3:0] spd, input logic [9:0] gpio,
                           input logic [5:0] i2c, input logic [3:0] uart, input logic dch,
                           input logic done, input logic err);
      chk($sformatf("%s.u%0d.spd", tag, k),  32'(o_spd[k]),  32'(spd));
      chk($sformatf("%s.u%0d.gpio", tag, k), 32'(o_gpio[k]), 32'(gpio));
      chk($sformatf("%s.u%0d.i2c", tag, k),  32'(o_i2c[k]),  32'(i2c));
      chk($sformatf("%s.u%0d.uart", tag, k), 32'(o_uart[k]), 32'(uart));
      chk($sformatf("%s.u%0d.dch", tag, k),  32'(o_dch[k]),  32'(dch));
      chk($sformatf("%s.u%0d.done", tag, k), 32'(o_done[k]), 32'(done));
      chk($sformatf("%s.u%0d.err", tag, k),  32'(o_err[k]),  32'(err));
   endtask

   task automatic drive(input logic [15:0] s, input logic [9:0] g, input logic [5:0] i,
                        input logic [3:0] u, input logic d);
      r_spd = s; r_gpio = g; r_i2c = i; r_uart = u; r_dch = d;
   endtask

   // One-cycle strobe launched on a falling edge; results are sampled on the next falling edge.
   task automatic strobe(input logic [15:0] s, input logic [9:0] g, input logic [5:0] i,
                         input logic [3:0] u, input logic d);
      @(negedge clk);
      drive(s, g, i, u, d);
      remote_valid = 1'b1;
      @(negedge clk);
      remote_valid = 1'b0;
   endtask

   initial begin
      // Reset, with a strobe that must be ignored
      @(negedge clk);
      drive(16'h000F, 10'd100, 6'h3F, 4'hF, 1'b1);
      remote_valid = 1'b1;
      @(negedge clk);
      remote_valid = 1'b0;
      for (int k = 0; k < 3; k++) chk_oper(k, "rst", 4'd0, 10'd0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      chk("loc.c0.spd", 32'(l_spd[0]), 32'h000F);
      chk("loc.c0.gpio", 32'(l_gpio[0]), 32'd64);
      chk("loc.c0.i2c", 32'(l_i2c[0]), 32'h3F);
      chk("loc.c0.uart", 32'(l_uart[0]), 32'h3);
      chk("loc.c0.dch", 32'(l_dch[0]), 32'(DCH));
      chk("loc.t.spd", 32'(l_spd[2]), 32'h0007);
      chk("loc.t.i2c", 32'(l_i2c[2]), 32'h03);

      @(negedge clk);
      reset_n = 1'b1;

      // Controller negotiation; check one-cycle latency
      @(negedge clk);
      drive(16'h0005, 10'd100, 6'b101010, 4'b0110, 1'b1);
      remote_valid = 1'b1;
      #1 chk("lat.c0.done_before", 32'(o_done[0]), 32'd0);
      @(negedge clk);
      remote_valid = 1'b0;
      chk_oper(0, "neg1", 4'd2, 10'd64, 6'b101010, 4'b0010, DCH, 1'b1, 1'b0);
      chk_oper(1, "neg1", 4'd0, 10'd64, 6'b101010, 4'b0010, DCH, 1'b1, 1'b0);
      chk_oper(2, "neg1", 4'd0, 10'd0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b1);

      // Clear, then empty common speed set on c1
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      for (int k = 0; k < 3; k++) chk_oper(k, "clr", 4'd0, 10'd0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      strobe(16'h0002, 10'd100, 6'b101010, 4'b0110, 1'b1);
      chk_oper(1, "nospd", 4'd0, 10'd0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      chk_oper(0, "nospd", 4'd1, 10'd64, 6'b101010, 4'b0010, DCH, 1'b1, 1'b0);
      chk_oper(2, "nospd", 4'd0, 10'd0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b1);

      // Target accept, reject on gpio, reject on uart subset, accept at gpio boundary
      strobe(16'h0004, 10'd32, 6'b000011, 4'b0001, 1'b1);
      chk_oper(2, "tacc", 4'd2, 10'd32, 6'b000011, 4'b0001, DCH, 1'b1, 1'b0);
      strobe(16'h0004, 10'd65, 6'b000011, 4'b0001, 1'b1);
      chk_oper(2, "trej", 4'd2, 10'd32, 6'b000011, 4'b0001, DCH, 1'b0, 1'b1);
      strobe(16'h0002, 10'd10, 6'b000000, 4'b0100, 1'b0);
      chk_oper(2, "trejuart", 4'd2, 10'd32, 6'b000011, 4'b0001, DCH, 1'b0, 1'b1);
      strobe(16'h0001, 10'd64, 6'b000010, 4'b0000, 1'b0);
      chk_oper(2, "tedge", 4'd0, 10'd64, 6'b000010, 4'b0000, 1'b0, 1'b1, 1'b0);

      // Back-to-back strobes: last one wins
      @(negedge clk);
      drive(16'h0008, 10'd10, 6'h3F, 4'hF, 1'b0);
      remote_valid = 1'b1;
      @(negedge clk);
      drive(16'h0003, 10'd20, 6'b000100, 4'b0001, 1'b1);
      @(negedge clk);
      remote_valid = 1'b0;
      chk_oper(0, "b2b", 4'd1, 10'd20, 6'b000100, 4'b0001, DCH, 1'b1, 1'b0);

      // clear beats a simultaneous strobe
      @(negedge clk);
      drive(16'h000F, 10'd50, 6'h3F, 4'hF, 1'b1);
      remote_valid = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      remote_valid = 1'b0;
      clear = 1'b0;
      chk_oper(0, "clrpri", 4'd0, 10'd0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-run
      strobe(16'h000F, 10'd50, 6'h3F, 4'hF, 1'b1);
      chk_oper(0, "prearst", 4'd3, 10'd50, 6'h3F, 4'h3, DCH, 1'b1, 1'b0);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 chk_oper(0, "arst", 4'd0, 10'd0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
